vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
Two-port front end for the 32KB synchronous video RAM. It time-shares the single RAM port between a pipelined video scanout fetcher (priority port) and a CPU bus port with a req/ack handshake. A starvation counter bounds CPU wait. A 2-stage ownership tag pipeline matches the RAM's 2-edge read latency and routes each returning byte to its requester.

Parameters:
ADDR_WIDTH, 15, RAM byte address width
DATA_WIDTH, 8, RAM data width
STARVE_LIMIT, 4, max consecutive cycles a pending CPU request loses to video before it is forced through (>=1)
CNT_WIDTH, 3, starvation counter width, must hold STARVE_LIMIT

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
vid_req  in  1  video fetch request for this cycle (single-cycle, may be back-to-back)
vid_addr  in  ADDR_WIDTH  video fetch address, valid with vid_req
vid_gnt  out  1  comb; vid_req accepted this cycle (low = fetcher must retry)
vid_valid  out  1  vid_data valid this cycle
vid_data  out  DATA_WIDTH  returned video byte
cpu_req  in  1  CPU access request, held with addr/we/wdata until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_WIDTH  CPU address
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_WIDTH  read data, valid while cpu_ack=1 and access was a read
ram_addr  out  ADDR_WIDTH  to RAM address input
ram_we  out  1  to RAM write enable
ram_wdata  out  DATA_WIDTH  to RAM data input
ram_rdata  in  DATA_WIDTH  from RAM data output

Behaviour:
- RAM contract: addr/we/wdata sampled at edge ending cycle T; read data on ram_rdata during cycle T+2.
- Grant decision (comb, cycle T): cpu_pend = cpu_req & ~cpu_busy.
  - force = cpu_pend & (starve_cnt == STARVE_LIMIT).
  - If force: CPU granted, vid_gnt=0.
  - Else if vid_req: video granted, vid_gnt=1.
  - Else if cpu_pend: CPU granted.
  - Else idle: ram_we=0, ram_addr holds the last granted address.
- RAM drive: ram_addr/ram_we/ram_wdata are muxed combinationally from the granted port. Video grant forces ram_we=0.
- starve_cnt:
  - Cleared on CPU grant or when cpu_pend=0.
  - Incremented when cpu_pend & video granted.
  - Saturates at STARVE_LIMIT.
- cpu_busy: set at the end of the CPU-grant cycle T; cleared at the end of T+2. cpu_req still high in T+3 is a new request.
- Tag pipeline: tag0 <= {vid_granted, cpu_granted} at end of T; tag1 <= tag0 at end of T+1. In T+2:
  - vid_valid = tag1.vid; vid_data = ram_rdata.
  - cpu_ack = tag1.cpu; cpu_rdata = ram_rdata.
  - Writes ack at T+2 like reads; cpu_rdata is don't-care for writes.
- Latency: video read 2 cycles grant-to-valid, fully pipelined (1 byte/cycle). CPU access 2 cycles grant-to-ack when uncontended; worst case STARVE_LIMIT+2.
- vid_valid and cpu_ack are never high in the same cycle. Order of video returns equals grant order.
- Reset (sync, while high and on the first cycle after):
  - tags, cpu_busy, starve_cnt and ram_addr register all cleared to 0.
  - vid_gnt=0, ram_we=0 (forced even if requests present), vid_valid=0, cpu_ack=0.
  - Reset mid-flight discards in-flight tags: no ack/valid is produced for them, and the requester re-issues.
- Simultaneous events: vid_req and CPU write in the same cycle with cnt<LIMIT → video wins, write deferred, and no RAM write occurs that cycle.
- cpu_req deasserted before ack: illegal. If cpu_busy=1, the access still completes and acks.

Test Plan:
- Idle CPU read: cpu_req=1, we=0, addr=0x0123 (RAM[0x0123]=0x5A), no video → ram_addr=0x0123 in T, cpu_ack=1 with cpu_rdata=0x5A in T+2; no second grant in T+1/T+2.
- CPU write then read: write 0xA5 to 0x7FFF, then read 0x7FFF → ram_we=1 for exactly 1 cycle; ack 2 cycles after each grant; read returns 0xA5.
- Video burst: vid_req every cycle for addr 0x0000..0x000F → vid_gnt=1 all 16 cycles; vid_valid 2 cycles later for 16 consecutive cycles with bytes in address order.
- Starvation: continuous vid_req plus CPU read 0x0040, STARVE_LIMIT=4 → 4 video grants, then vid_gnt=0 in cycle 5 with CPU granted; cpu_ack 2 cycles later; video resumes next cycle.
- Collision write: vid_req and CPU write 0x0010=0x33 in the same cycle → video granted, ram_we=0 that cycle; write lands on the next non-video or forced cycle; readback=0x33.
- Reset mid-flight: assert reset the cycle after a CPU grant → cpu_ack never pulses for that request, ram_we=0 during reset, and all outputs are 0. Re-issue after reset completes normally.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Bus bundle for the video RAM arbiter: video fetch port, CPU port and RAM port.
interface vram_arbiter_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
);
  logic                  vid_req;
  logic [ADDR_WIDTH-1:0] vid_addr;
  logic                  vid_gnt;
  logic                  vid_valid;
  logic [DATA_WIDTH-1:0] vid_data;
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_ack;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vid_gnt, vid_valid, vid_data, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vid_gnt, vid_valid, vid_data, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Time-shares one synchronous video RAM port between a priority video fetcher
// and a CPU req/ack port, with a starvation bound on CPU wait and a 2-stage
// ownership tag pipeline matching the RAM's 2-edge read latency.
module vram_arbiter #(
  parameter int ADDR_WIDTH   = 15,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic           clk,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  logic                  cpu_busy;
  logic [CNT_WIDTH-1:0]  starve_cnt;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  tag_vid_p0, tag_cpu_p0;
  logic                  tag_vid_p1, tag_cpu_p1;
  logic                  cpu_pend, force_cpu;
  logic                  vid_grant, cpu_grant;

  // A CPU request is only pending once the previous CPU access has returned.
  assign cpu_pend  = bus.cpu_req & ~cpu_busy;
  assign force_cpu = cpu_pend & (starve_cnt == LIMIT);

  // Grant decision: forced CPU beats video, video beats a normal CPU request.
  always_comb begin
    vid_grant = 1'b0;
    cpu_grant = 1'b0;
    if (!reset) begin
      if (force_cpu)        cpu_grant = 1'b1;
      else if (bus.vid_req) vid_grant = 1'b1;
      else if (cpu_pend)    cpu_grant = 1'b1;
    end
  end

  // RAM port mux; idle cycles keep the last granted address on the bus.
  always_comb begin
    bus.ram_addr  = last_addr;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    if (reset) begin
      bus.ram_addr = '0;
    end else if (vid_grant) begin
      bus.ram_addr = bus.vid_addr;
    end else if (cpu_grant) begin
      bus.ram_addr  = bus.cpu_addr;
      bus.ram_we    = bus.cpu_we;
      bus.ram_wdata = bus.cpu_wdata;
    end
  end

  assign bus.vid_gnt = vid_grant;

  // Return routing: the tag that left stage p1 owns the byte now on ram_rdata.
  always_comb begin
    bus.vid_valid = tag_vid_p1 & ~reset;
    bus.cpu_ack   = tag_cpu_p1 & ~reset;
    bus.vid_data  = bus.vid_valid ? bus.ram_rdata : '0;
    bus.cpu_rdata = bus.cpu_ack   ? bus.ram_rdata : '0;
  end

  // Tag pipeline, CPU busy window, starvation counter and held address.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vid_p0 <= 1'b0;
      tag_cpu_p0 <= 1'b0;
      tag_vid_p1 <= 1'b0;
      tag_cpu_p1 <= 1'b0;
      cpu_busy   <= 1'b0;
      starve_cnt <= '0;
      last_addr  <= '0;
    end else begin
      // stage p0: ownership of the access issued this cycle
      tag_vid_p0 <= vid_grant;
      tag_cpu_p0 <= cpu_grant;
      // stage p1: ownership of the byte returned next cycle
      tag_vid_p1 <= tag_vid_p0;
      tag_cpu_p1 <= tag_cpu_p0;

      if (cpu_grant)       cpu_busy <= 1'b1;
      else if (tag_cpu_p1) cpu_busy <= 1'b0;

      if (cpu_grant || !cpu_pend)             starve_cnt <= '0;
      else if (vid_grant && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;

      if (vid_grant)      last_addr <= bus.vid_addr;
      else if (cpu_grant) last_addr <= bus.cpu_addr;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: bench-side RAM, a transaction-level
// scoreboard checked every cycle, plus hand-computed scenario expectations.
module tb_vram_arbiter;
  localparam int AW = 15;
  localparam int DW = 8;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM), .CNT_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  // ---------------- RAM: 2-edge read latency ----------------
  logic [7:0] ram_arr [0:32767];
  logic [7:0] rd_p0;
  logic [7:0] ref_mem [0:32767];

  initial begin
    for (int i = 0; i < 32768; i++) begin
      ram_arr[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end
    ram_arr[15'h0123] = 8'h5A;
    ref_mem[15'h0123] = 8'h5A;
  end

  always @(posedge clk) begin
    rd_p0 <= ram_arr[bus.ram_addr];
    bus.ram_rdata <= rd_p0;
    if (bus.ram_we) ram_arr[bus.ram_addr] <= bus.ram_wdata;
  end

  // ---------------- scoreboard model ----------------
  typedef struct {
    int         due;
    bit         is_vid;
    bit         is_read;
    logic [7:0] d;
  } ret_t;
  ret_t exp_q[$];
  int   cyc_n = 0;
  int   last_cpu_g = -100;
  int   wait_n = 0;
  logic [AW-1:0] hold_addr = '0;

  always @(negedge clk) begin
    bit pend, forced, vg, cg, ev, ec;
    logic [AW-1:0] ea;
    logic [7:0] ed;
    bit erd;
    if (reset) begin
      chk("rst_vid_gnt", int'(bus.vid_gnt), 0);
      chk("rst_ram_we", int'(bus.ram_we), 0);
      chk("rst_ram_addr", int'(bus.ram_addr), 0);
      chk("rst_cpu_ack", int'(bus.cpu_ack), 0);
      chk("rst_vid_valid", int'(bus.vid_valid), 0);
      exp_q.delete();
      last_cpu_g = -100;
      wait_n = 0;
      hold_addr = '0;
    end else begin
      pend   = bus.cpu_req && (cyc_n - last_cpu_g > 2);
      forced = pend && (wait_n >= LIM);
      vg     = !forced && bus.vid_req;
      cg     = pend && !vg;
      wait_n = (pend && vg) ? wait_n + 1 : 0;
      ea = vg ? bus.vid_addr : (cg ? bus.cpu_addr : hold_addr);
      chk("m_vid_gnt", int'(bus.vid_gnt), int'(vg));
      chk("m_ram_we", int'(bus.ram_we), int'(cg && bus.cpu_we));
      chk("m_ram_addr", int'(bus.ram_addr), int'(ea));
      if (cg && bus.cpu_we) chk("m_ram_wdata", int'(bus.ram_wdata), int'(bus.cpu_wdata));
      ev = 0; ec = 0; ed = '0; erd = 0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc_n) begin
        ev  = exp_q[0].is_vid;
        ec  = !exp_q[0].is_vid;
        ed  = exp_q[0].d;
        erd = exp_q[0].is_read;
        void'(exp_q.pop_front());
      end
      chk("m_vid_valid", int'(bus.vid_valid), int'(ev));
      chk("m_cpu_ack", int'(bus.cpu_ack), int'(ec));
      if (ev) chk("m_vid_data", int'(bus.vid_data), int'(ed));
      if (ec && erd) chk("m_cpu_rdata", int'(bus.cpu_rdata), int'(ed));
      if (vg) exp_q.push_back('{cyc_n + 2, 1'b1, 1'b1, ref_mem[bus.vid_addr]});
      if (cg) begin
        exp_q.push_back('{cyc_n + 2, 1'b0, !bus.cpu_we, ref_mem[bus.cpu_addr]});
        last_cpu_g = cyc_n;
        if (bus.cpu_we) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
      end
      if (vg || cg) hold_addr = ea;
    end
    cyc_n++;
  end

  // ---------------- directed stimulus ----------------
  int gnt_log [0:31];
  int we_log  [0:31];
  int addr_log[0:31];

  // One CPU access with an optional concurrent video stream for vid_n cycles.
  task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                        input int vid_n, input logic [AW-1:0] vbase,
                        input int exp_lat, input string nm, output logic [7:0] rd);
    int  n_we;
    int  lat;
    bit  got;
    n_we = 0; lat = -1; got = 0; rd = '0;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    for (int c = 0; c < 24 && !got; c++) begin
      bus.vid_req  = (c < vid_n);
      bus.vid_addr = vbase + AW'(c);
      @(negedge clk);
      gnt_log[c]  = int'(bus.vid_gnt);
      we_log[c]   = int'(bus.ram_we);
      addr_log[c] = int'(bus.ram_addr);
      if (bus.ram_we) n_we++;
      if (bus.cpu_ack) begin
        got = 1; lat = c; rd = bus.cpu_rdata;
      end
      @(posedge clk); #1;
    end
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.vid_req = 1'b0;
    if (!got) chk({nm, "_timeout"}, 0, 1);
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_n_we"}, n_we, we ? 1 : 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [7:0] rd;
    int nv, ng;
    bus.vid_req = 0; bus.vid_addr = '0; bus.cpu_req = 0; bus.cpu_we = 0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ram_addr", int'(bus.ram_addr), 0);
    chk("post_rst_cpu_ack", int'(bus.cpu_ack), 0);
    @(posedge clk); #1;

    // Idle CPU read
    cpu_op(1'b0, 15'h0123, 8'h00, 0, '0, 2, "rd0123", rd);
    chk("rd0123_data", int'(rd), 8'h5A);
    chk("rd0123_addr_T", addr_log[0], 15'h0123);
    chk("rd0123_addr_T1", addr_log[1], 15'h0123);
    idle(2);

    // CPU write then read at top address
    cpu_op(1'b1, 15'h7FFF, 8'hA5, 0, '0, 2, "wr7fff", rd);
    idle(1);
    cpu_op(1'b0, 15'h7FFF, 8'h00, 0, '0, 2, "rd7fff", rd);
    chk("rd7fff_data", int'(rd), 8'hA5);
    idle(2);

    // Video burst 0x0000..0x000F
    nv = 0; ng = 0;
    for (int c = 0; c < 20; c++) begin
      bus.vid_req  = (c < 16);
      bus.vid_addr = AW'(c);
      @(negedge clk);
      if (bus.vid_gnt) ng++;
      if (bus.vid_valid) begin
        chk("burst_data", int'(bus.vid_data), int'(init_val(nv)));
        chk("burst_slot", c, nv + 2);
        nv++;
      end
      @(posedge clk); #1;
    end
    bus.vid_req = 1'b0;
    chk("burst_gnt_cnt", ng, 16);
    chk("burst_valid_cnt", nv, 16);
    idle(2);

    // Starvation: continuous video plus CPU read of 0x0040
    cpu_op(1'b0, 15'h0040, 8'h00, 32, 15'h0100, LIM + 2, "starve", rd);
    chk("starve_data", int'(rd), 8'hC3);
    chk("starve_g0", gnt_log[0], 1);
    chk("starve_g3", gnt_log[3], 1);
    chk("starve_g4", gnt_log[4], 0);
    chk("starve_addr4", addr_log[4], 15'h0040);
    chk("starve_g5", gnt_log[5], 1);
    idle(3);

    // Collision: video and CPU write in the same cycle
    cpu_op(1'b1, 15'h0010, 8'h33, 1, 15'h0200, 3, "coll", rd);
    chk("coll_g0", gnt_log[0], 1);
    chk("coll_we0", we_log[0], 0);
    chk("coll_we1", we_log[1], 1);
    idle(1);
    cpu_op(1'b0, 15'h0010, 8'h00, 0, '0, 2, "coll_rb", rd);
    chk("coll_rb_data", int'(rd), 8'h33);
    idle(2);

    // Reset the cycle after a CPU grant
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'h0200;
    @(negedge clk);
    chk("rmf_grant_addr", int'(bus.ram_addr), 15'h0200);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.cpu_we = 1'b1; bus.cpu_addr = 15'h0300; bus.cpu_wdata = 8'hEE;
    bus.vid_req = 1'b1; bus.vid_addr = 15'h0055;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      chk("rmf_ram_we", int'(bus.ram_we), 0);
      chk("rmf_vid_gnt", int'(bus.vid_gnt), 0);
      chk("rmf_cpu_ack", int'(bus.cpu_ack), 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.vid_req = 1'b0;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      chk("rmf_no_ack", int'(bus.cpu_ack), 0);
      @(posedge clk); #1;
    end
    cpu_op(1'b0, 15'h0200, 8'h00, 0, '0, 2, "rmf_reissue", rd);
    chk("rmf_reissue_data", int'(rd), 8'h03);
    idle(1);
    cpu_op(1'b0, 15'h0300, 8'h00, 0, '0, 2, "rmf_nowrite", rd);
    chk("rmf_nowrite_data", int'(rd), 8'h03);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
